// File: rtl/fifo_wr_arbiter.sv
// Two-source round-robin arbiter for the FIFO byte write port.
// Grants are burst-limited; overflow freezes acceptance and counts stalled cycles.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  parameter int STALL_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               req0,
  input  logic [DATA_W-1:0]  data0,
  output logic               ack0,
  input  logic               req1,
  input  logic [DATA_W-1:0]  data1,
  output logic               ack1,
  input  logic               overflow,
  output logic [DATA_W-1:0]  DB,
  output logic               wr,
  output logic               owner,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         burst_cnt_q, burst_cnt_d;
  logic               last_served_q, last_served_d;
  logic [DATA_W-1:0]  db_q, db_d;
  logic               wr_q, wr_d;
  logic               owner_q, owner_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic              cur_id_s;
  logic              cur_req_s;
  logic              oth_req_s;
  logic [DATA_W-1:0] cur_data_s;
  logic [3:0]        burst_next_s;
  logic              grant_s;
  logic              grant_id_s;

  assign ack0      = (state_q == GNT0) & ~overflow & Rst;
  assign ack1      = (state_q == GNT1) & ~overflow & Rst;
  assign DB        = db_q;
  assign wr        = wr_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign stall_cnt = stall_cnt_q;

  // Next-state, burst accounting and write-port capture.
  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    last_served_d = last_served_q;
    db_d          = db_q;
    wr_d          = 1'b0;
    owner_d       = owner_q;
    stall_cnt_d   = stall_cnt_q;
    grant_s       = 1'b0;
    grant_id_s    = 1'b0;

    cur_id_s     = (state_q == GNT1);
    cur_req_s    = cur_id_s ? req1 : req0;
    oth_req_s    = cur_id_s ? req0 : req1;
    cur_data_s   = cur_id_s ? data1 : data0;
    burst_next_s = burst_cnt_q + 4'd1;

    if (overflow && (req0 || req1) && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    // While the FIFO is full everything except the stall counter freezes.
    if (!overflow) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            grant_s    = 1'b1;
            grant_id_s = ~last_served_q;
          end else if (req0 || req1) begin
            grant_s    = 1'b1;
            grant_id_s = req1;
          end else begin
            grant_s    = 1'b0;
          end
        end
        GNT0, GNT1: begin
          if (cur_req_s) begin
            wr_d        = 1'b1;
            db_d        = cur_data_s;
            owner_d     = cur_id_s;
            burst_cnt_d = burst_next_s;
          end else begin
            wr_d        = 1'b0;
          end
          if (!cur_req_s || (burst_next_s == 4'(BURST_MAX))) begin
            if (oth_req_s) begin
              grant_s    = 1'b1;
              grant_id_s = ~cur_id_s;
            end else if (cur_req_s) begin
              grant_s    = 1'b1;
              grant_id_s = cur_id_s;
            end else begin
              state_d    = IDLE;
            end
          end else begin
            grant_s = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (grant_s) begin
      state_d       = grant_id_s ? GNT1 : GNT0;
      burst_cnt_d   = 4'd0;
      last_served_d = grant_id_s;
    end else begin
      last_served_d = last_served_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q       <= IDLE;
      burst_cnt_q   <= 4'd0;
      last_served_q <= 1'b1;
      db_q          <= {DATA_W{1'b0}};
      wr_q          <= 1'b0;
      owner_q       <= 1'b0;
      stall_cnt_q   <= {STALL_W{1'b0}};
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      last_served_q <= last_served_d;
      db_q          <= db_d;
      wr_q          <= wr_d;
      owner_q       <= owner_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of grants and writes.
module tb_fifo_wr_arbiter;
  localparam int BURST = 4;
  localparam int SMAX  = 15;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       req0 = 1'b1, req1 = 1'b1, overflow = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, wr, owner, busy;
  logic [7:0] DB;
  logic [3:0] stall_cnt;

  fifo_wr_arbiter #(.DATA_W(8), .BURST_MAX(BURST), .STALL_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1), .overflow(overflow),
    .DB(DB), .wr(wr), .owner(owner), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: who holds the grant (-1 = nobody), how many bytes it has moved,
  // who was served last, and the write that will be visible next cycle.
  int         m_grant = -1;
  int         m_taken = 0;
  int         m_last  = 1;
  int         m_stall = 0;
  logic       m_wr    = 1'b0;
  logic [7:0] m_db    = 8'h00;
  logic       m_own   = 1'b0;

  int         cyc = 0;
  logic       lg_own[$];
  logic [7:0] lg_db[$];
  int         lg_cyc[$];

  task automatic m_start(input int i);
    m_grant = i;
    m_taken = 0;
    m_last  = i;
  endtask

  task automatic m_step();
    logic nw;
    logic rg, ro;
    int   g;
    nw = 1'b0;
    if (!Rst) begin
      m_grant = -1; m_taken = 0; m_last = 1; m_stall = 0;
      m_db = 8'h00; m_own = 1'b0;
    end else begin
      if (overflow && (req0 || req1)) m_stall = (m_stall == SMAX) ? SMAX : m_stall + 1;
      if (!overflow) begin
        if (m_grant < 0) begin
          if (req0 && req1) m_start(1 - m_last);
          else if (req0)    m_start(0);
          else if (req1)    m_start(1);
        end else begin
          g  = m_grant;
          rg = (g == 0) ? req0 : req1;
          ro = (g == 0) ? req1 : req0;
          if (rg) begin
            nw = 1'b1;
            m_db = (g == 0) ? data0 : data1;
            m_own = (g == 1);
            m_taken++;
          end
          if (!rg || m_taken == BURST) begin
            if (ro)      m_start(1 - g);
            else if (rg) m_start(g);
            else         m_grant = -1;
          end
        end
      end
    end
    m_wr = nw;
  endtask

  // Per-cycle comparison of the DUT against the model, then advance the model.
  always @(negedge Clk) begin
    chk("ack0", 32'(ack0), 32'(Rst && m_grant == 0 && !overflow));
    chk("ack1", 32'(ack1), 32'(Rst && m_grant == 1 && !overflow));
    chk("wr", 32'(wr), 32'(m_wr));
    if (m_wr) begin
      chk("DB", 32'(DB), 32'(m_db));
      chk("owner", 32'(owner), 32'(m_own));
    end
    chk("busy", 32'(busy), 32'(m_grant >= 0));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (wr === 1'b1) begin
      lg_own.push_back(owner);
      lg_db.push_back(DB);
      lg_cyc.push_back(cyc);
    end
    cyc++;
    m_step();
  end

  logic       x0 = 1'b0, x1 = 1'b0;
  int         n0 = 0, n1 = 0;
  logic       rnd = 1'b0;
  logic [7:0] nd0 = 8'h11, nd1 = 8'hA0;

  task automatic tick();
    @(negedge Clk);
    x0 = req0 & ack0;
    x1 = req1 & ack1;
    if (x0) n0++;
    if (x1) n1++;
    @(posedge Clk);
    #1;
  endtask

  // Honour the source protocol: a waiting byte stays put until accepted or withdrawn.
  task automatic drive(input logic w0, input logic w1);
    if (w0) begin
      if (!req0 || x0) begin
        data0 = rnd ? 8'($urandom) : nd0;
        nd0 = nd0 + 8'h11;
      end
      req0 = 1'b1;
    end else begin
      req0 = 1'b0;
    end
    if (w1) begin
      if (!req1 || x1) begin
        data1 = rnd ? 8'($urandom) : nd1;
        nd1 = nd1 + 8'h01;
      end
      req1 = 1'b1;
    end else begin
      req1 = 1'b0;
    end
  endtask

  task automatic clear_log();
    lg_own.delete();
    lg_db.delete();
    lg_cyc.delete();
  endtask

  task automatic reset_dut();
    Rst = 1'b0; req0 = 1'b0; req1 = 1'b0; overflow = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    n0 = 0; n1 = 0;
    clear_log();
  endtask

  int lead;

  initial begin
    // Reset with both requests asserted.
    tick();
    tick();
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_db", 32'(DB), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);

    // Single source: three bytes 0x11, 0x22, 0x33.
    req0 = 1'b0; req1 = 1'b0; Rst = 1'b1;
    tick();
    clear_log(); n0 = 0; nd0 = 8'h11;
    drive(1'b1, 1'b0);
    #1 chk("single_ack_idle", 32'(ack0), 32'd0);
    tick();
    chk("single_ack_next", 32'(ack0), 32'd1);
    for (int k = 0; k < 12 && n0 < 3; k++) begin
      drive(n0 < 3, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0);
    tick(); tick(); tick();
    chk("single_count", 32'(lg_db.size()), 32'd3);
    if (lg_db.size() == 3) begin
      chk("single_b0", 32'(lg_db[0]), 32'h11);
      chk("single_b1", 32'(lg_db[1]), 32'h22);
      chk("single_b2", 32'(lg_db[2]), 32'h33);
      chk("single_own", 32'({lg_own[0], lg_own[1], lg_own[2]}), 32'd0);
    end

    // Contention: 4-byte bursts alternating 0,1,0,1 with no gap.
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0);
    tick(); tick(); tick();
    chk("cont_count_ge16", 32'(lg_own.size() >= 16), 32'd1);
    if (lg_own.size() >= 16) begin
      for (int k = 0; k < 16; k++) chk("cont_owner", 32'(lg_own[k]), 32'((k / 4) % 2));
      for (int k = 0; k < 15; k++) chk("cont_gap", 32'(lg_cyc[k+1] - lg_cyc[k]), 32'd1);
    end

    // Backpressure: overflow for 5 cycles after 2 of requester 1's bytes.
    reset_dut();
    for (int k = 0; k < 10 && n1 < 2; k++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    chk("bp_reach2", 32'(n1), 32'd2);
    begin
      int s0;
      s0 = int'(stall_cnt);
      for (int k = 0; k < 5; k++) begin
        overflow = 1'b1;
        drive(1'b1, 1'b1);
        #1;
        chk("bp_ack1_low", 32'(ack1), 32'd0);
        chk("bp_ack0_low", 32'(ack0), 32'd0);
        tick();
      end
      chk("bp_stall_plus5", 32'(int'(stall_cnt) - s0), 32'd5);
    end
    overflow = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0);
    tick(); tick();
    lead = 0;
    while (lead < lg_own.size() && lg_own[lead] == 1'b1) lead++;
    chk("bp_burst_len", 32'(lead), 32'd4);
    chk("bp_then_owner0", 32'(lead < lg_own.size() && lg_own[lead] == 1'b0), 32'd1);
    if (lg_cyc.size() >= 3) chk("bp_gap", 32'(lg_cyc[2] - lg_cyc[1]), 32'd6);
    else chk("bp_gap_size", 32'(lg_cyc.size()), 32'd3);

    // Withdraw: requester 0 leaves after 2 bytes, requester 1 waiting.
    reset_dut();
    for (int k = 0; k < 10 && n0 < 2; k++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    chk("wd_reach2", 32'(n0), 32'd2);
    drive(1'b0, 1'b1);
    tick();
    chk("wd_ack1", 32'(ack1), 32'd1);
    drive(1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0);
    tick(); tick();
    chk("wd_size_ge3", 32'(lg_own.size() >= 3), 32'd1);
    if (lg_own.size() >= 3)
      chk("wd_owners", 32'({lg_own[0], lg_own[1], lg_own[2]}), 32'b001);

    // Reset mid-burst: the queued write is dropped, requester 0 wins next.
    reset_dut();
    for (int k = 0; k < 10 && n0 < 1; k++) begin
      drive(1'b1, 1'b0);
      tick();
    end
    chk("rmb_reach1", 32'(n0), 32'd1);
    Rst = 1'b0;
    drive(1'b1, 1'b1);
    tick();
    chk("rmb_wr_dropped", 32'(wr), 32'd0);
    chk("rmb_busy", 32'(busy), 32'd0);
    Rst = 1'b1;
    clear_log();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    chk("rmb_first_owner", (lg_own.size() > 0) ? 32'(lg_own[0]) : 32'hFFFF, 32'd0);

    // Stall counter saturation.
    for (int k = 0; k < 20; k++) begin
      overflow = 1'b1;
      drive(1'b1, 1'b0);
      tick();
    end
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    overflow = 1'b0;
    drive(1'b0, 1'b0);
    tick(); tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);

    // Random traffic, checked cycle by cycle against the model.
    rnd = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      Rst      = ($urandom_range(0, 299) != 0);
      overflow = ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 1'b0);
    overflow = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
